serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Moore-style serial transmitter that drives the single-bit `in` stream consumed by the team's serial FSM detectors.
- Accepts a parallel word over a valid/ready handshake and serialises it on one line: start marker, data bits LSB-first, optional parity bit, stop bit, then an optional idle gap.
- Used as the stimulus/link source in front of the detector blocks and as a standalone line driver.

Parameters:
- WIDTH, 8, data word width in bits (legal range 1..32).
- PARITY_EN, 1, 1 inserts a parity bit after the data bits; 0 omits it.
- PARITY_ODD, 0, 0 selects even parity; 1 selects odd parity (ignored if PARITY_EN=0).
- GAP_CYCLES, 1, forced idle cycles after the stop bit before the next word is accepted (0..15).

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low (0 = reset asserted); clears all state immediately; release is sampled on clk.
- in_valid, input, 1, upstream word available.
- in_data, input, WIDTH, word to transmit; sampled only on acceptance.
- in_ready, output, 1, block can accept a word this cycle.
- out, output, 1, serial line.
- busy, output, 1, frame or gap in progress.
- frame_done, output, 1, single-cycle pulse during the stop bit.

Behaviour:
- States: IDLE, START, DATA, PARITY, STOP, GAP. All outputs are decoded from registered state and shift register only (Moore); no input-to-output combinational path.
- Reset (reset=0, any time, including mid-frame):
  - State goes to IDLE; bit counter, gap counter and shift register are cleared.
  - Outputs: out=0, busy=0, frame_done=0, in_ready=1.
  - A partial frame is abandoned and not resumed.
- IDLE:
  - Drives out=0, in_ready=1, busy=0.
  - Acceptance occurs when in_valid=1 at a rising edge. in_data is latched into the shift register and the state goes to START.
  - Changes on in_data after acceptance have no effect.
- START: one cycle, out=1, next state DATA.
- DATA:
  - WIDTH cycles; out = shift register bit 0, which shifts right each cycle.
  - The bit counter runs 0..WIDTH-1.
  - At count WIDTH-1 the next state is PARITY if PARITY_EN=1, otherwise STOP.
- PARITY:
  - One cycle; out = XOR of all latched data bits, XOR PARITY_ODD.
  - The parity value is computed at acceptance or accumulated during DATA; either way it must reflect the latched word.
- STOP:
  - One cycle; out=0, frame_done=1.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
- GAP: GAP_CYCLES cycles; out=0. Next state IDLE.
- in_ready=1 only in IDLE. A word held with in_valid=1 during a frame is not taken until IDLE.
- busy=1 in every state except IDLE.
- Frame length = 1 + WIDTH + PARITY_EN + 1 cycles.
- Latency: the start bit appears on out in the first cycle after the accepting edge.
- Back-to-back throughput: one word per (frame length + GAP_CYCLES + 1) cycles. The IDLE cycle is mandatory.
- Width rules:
  - Bit counter is clog2(WIDTH) bits wide, minimum 1.
  - Gap counter is 4 bits.
  - The gap counter must saturate/compare exactly; no wrap past GAP_CYCLES.
- Illegal state encodings return to IDLE on the next edge.

Test Plan:
- Reset release, in_valid=0 for 5 cycles -> out=0, in_ready=1, busy=0, frame_done=0 throughout.
- Defaults; send 0xA5 with in_valid pulsed one cycle -> out in cycles 1..11 after acceptance = 1, 1,0,1,0,0,1,0,1, 0 (even parity, four ones), 0 (stop); frame_done=1 only in cycle 11; in_ready=0 in cycles 1..12; in_ready=1 again in cycle 13.
- PARITY_ODD=1; send 0x07 -> parity bit = 0 (three ones); send 0x00 -> parity bit = 1.
- PARITY_EN=0, GAP_CYCLES=0; hold in_valid=1 with 0xFF then 0x01 -> two frames of 10 cycles each separated by exactly one IDLE cycle; second frame data = 1,0,0,0,0,0,0,0.
- Change in_data from 0x3C to 0xC3 during DATA -> transmitted bits still match 0x3C (0,0,1,1,1,1,0,0).
- Assert reset=0 asynchronously in the 4th DATA cycle -> out=0 and busy=0 immediately without a clock edge; after release, in_ready=1; the next accepted word is sent in full from its start bit.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial line transmitter: start bit, LSB-first data, optional parity, stop bit, optional idle gap.
// Latency: the start bit appears on out in the first cycle after the accepting edge; frame is 2+WIDTH+PARITY_EN cycles.
// Backpressure: in_ready is high only in IDLE; a word offered mid-frame waits until the mandatory IDLE cycle.
module serial_frame_tx #(
   parameter int WIDTH      = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out,
   output logic             busy,
   output logic             frame_done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
   // Only meaningful when GAP_CYCLES > 0; the GAP state is unreachable otherwise.
   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
   localparam logic ODD_BIT = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      GAP    = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_q, bit_d;
   logic [3:0]       gap_q, gap_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             par_q, par_d;

   // State, counters, shift register and latched parity; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         bit_q   <= '0;
         gap_q   <= '0;
         shreg_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         shreg_q <= shreg_d;
         par_q   <= par_d;
      end
   end

   // Next-state sequencing; parity is computed once from the word at acceptance.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = START;
               shreg_d = in_data;
               par_d   = (^in_data) ^ ODD_BIT;
            end
         end
         START: begin
            state_d = DATA;
            bit_d   = '0;
         end
         DATA: begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + CW'(1);
            if (bit_q == BIT_LAST) begin
               bit_d   = '0;
               state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: begin
            state_d = STOP;
         end
         STOP: begin
            gap_d   = '0;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
         end
         GAP: begin
            gap_d = gap_q + 4'd1;
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            bit_d   = '0;
            gap_d   = '0;
            shreg_d = '0;
            par_d   = 1'b0;
         end
      endcase
   end

   // Moore output decode from registered state and shift register only.
   always_comb begin
      out        = 1'b0;
      in_ready   = 1'b0;
      busy       = 1'b1;
      frame_done = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
         end
         START:   out        = 1'b1;
         DATA:    out        = shreg_q[0];
         PARITY:  out        = par_q;
         STOP:    frame_done = 1'b1;
         GAP:     out        = 1'b0;
         default: out        = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx across four parameter sets, each with its own driver and line monitor.
// Expected line activity is built per accepted word as a list of per-cycle output tuples.
// The monitor compares {busy,in_ready,frame_done,out} every cycle; an empty list means idle.
module tb_serial_frame_tx;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   ncyc   = 0;

   always #5 clk = ~clk;

   // Free-running cycle index, advanced away from the active edge.
   always @(negedge clk) ncyc <= ncyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : cfg
      localparam int W   = (g == 3) ? 5 : 8;
      localparam int PE  = (g == 2) ? 0 : 1;
      localparam int PO  = (g == 1 || g == 3) ? 1 : 0;
      localparam int G   = (g == 2) ? 0 : ((g == 3) ? 3 : 1);
      localparam int LEN = 2 + W + PE + G;

      logic         reset;
      logic         in_valid;
      logic [W-1:0] in_data;
      logic         in_ready;
      logic         out;
      logic         busy;
      logic         frame_done;
      logic [3:0]   q[$];
      int           last_acc;
      bit           prev_hold;
      bit           fin = 1'b0;

      serial_frame_tx #(
         .WIDTH(W), .PARITY_EN(PE), .PARITY_ODD(PO), .GAP_CYCLES(G)
      ) dut (
         .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
         .in_ready(in_ready), .out(out), .busy(busy), .frame_done(frame_done)
      );

      // Reference frame: start, data LSB first, parity from the popcount, stop, gap.
      task automatic push_frame(input logic [W-1:0] w);
         int ones;
         ones = 0;
         q.push_back(4'b1001);
         for (int i = 0; i < W; i++) begin
            q.push_back({3'b100, w[i]});
            ones += int'(w[i]);
         end
         if (PE != 0) q.push_back({3'b100, 1'((ones + PO) % 2)});
         q.push_back(4'b1010);
         for (int i = 0; i < G; i++) q.push_back(4'b1000);
      endtask

      task automatic send(input logic [W-1:0] w, input bit hold, input logic [W-1:0] after);
         int guard;
         guard    = 0;
         in_valid = 1'b1;
         in_data  = w;
         while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         chk($sformatf("cfg%0d ready before accept", g), 32'(in_ready), 32'd1);
         @(posedge clk);
         if (prev_hold) chk($sformatf("cfg%0d back-to-back interval", g), 32'(ncyc - last_acc), 32'(LEN + 1));
         last_acc  = ncyc;
         prev_hold = hold;
         push_frame(w);
         #1;
         in_valid = hold;
         in_data  = after;
      endtask

      // Per-cycle line monitor against the expected queue.
      always @(negedge clk) begin : mon
         logic [3:0] e;
         e = (q.size() > 0) ? q.pop_front() : 4'b0100;
         chk($sformatf("cfg%0d line {busy,rdy,done,out}", g),
             {28'd0, busy, in_ready, frame_done, out}, {28'd0, e});
      end

      initial begin : drv
         int guard;
         int idle;
         reset     = 1'b0;
         in_valid  = 1'b0;
         in_data   = '0;
         prev_hold = 1'b0;
         last_acc  = 0;
         repeat (2) @(negedge clk);
         reset = 1'b1;
         repeat (5) @(negedge clk);

         send(W'(32'hA5), 1'b0, W'($urandom));
         send(W'(32'h07), 1'b0, W'($urandom));
         send(W'(32'h00), 1'b0, W'($urandom));
         send(W'(32'hFF), 1'b1, W'(32'h01));
         send(W'(32'h01), 1'b0, W'($urandom));
         send(W'(32'h3C), 1'b0, W'(32'hC3));

         // Asynchronous reset during the fourth data bit.
         send(W'(32'h5A), 1'b0, W'($urandom));
         repeat (4) @(posedge clk);
         #2;
         reset = 1'b0;
         #1;
         chk($sformatf("cfg%0d async reset out", g), 32'(out), 32'd0);
         chk($sformatf("cfg%0d async reset busy", g), 32'(busy), 32'd0);
         chk($sformatf("cfg%0d async reset ready", g), 32'(in_ready), 32'd1);
         chk($sformatf("cfg%0d async reset done", g), 32'(frame_done), 32'd0);
         q.delete();
         prev_hold = 1'b0;
         repeat (2) @(negedge clk);
         reset = 1'b1;
         @(negedge clk);
         send(W'(32'h96), 1'b0, W'($urandom));

         for (int n = 0; n < 25; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send(W'($urandom), hold, W'($urandom));
            if (!hold) begin
               idle = int'($urandom_range(0, 3));
               repeat (idle) begin
                  @(negedge clk);
                  in_data = W'($urandom);
               end
            end
         end
         in_valid = 1'b0;

         guard = 0;
         while (q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         chk($sformatf("cfg%0d expected queue drained", g), 32'(q.size()), 32'd0);
         repeat (3) @(negedge clk);
         fin = 1'b1;
      end
   end

   initial begin : finish_ctl
      fork
         wait (cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin);
         #500000;
      join_any
      disable fork;
      checks++;
      if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin && cfg[3].fin)) begin
         errors++;
         $display("FAIL run timeout: drivers finished %0b%0b%0b%0b expected 1111",
                  cfg[3].fin, cfg[2].fin, cfg[1].fin, cfg[0].fin);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
